vx_commit_writeback: RTL and testbench

//  Consumer of the per-unit commit streams (ALU, LSU, CSR, FPU, GPU). Arbitrates commits that

---
 rtl/vx_commit_pkg.sv | 34 +++
 rtl/vx_rr_arbiter.sv | 46 ++++
 rtl/vx_commit_writeback.sv | 127 ++++++++++++
 tb/tb_vx_commit_writeback.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vx_commit_pkg.sv
// Shared types and constants for the commit/writeback stage: commit source indices,
// per-source commit payload and the registered writeback packet.
package vx_commit_pkg;

    localparam int UUID_BITS   = 44;
    localparam int NW_BITS     = 2;
    localparam int NUM_THREADS = 4;
    localparam int NR_BITS     = 5;
    localparam int PERF_CTR_W  = 44;

    typedef enum logic [2:0] {
        SRC_ALU = 3'd0,
        SRC_LSU = 3'd1,
        SRC_CSR = 3'd2,
        SRC_FPU = 3'd3,
        SRC_GPU = 3'd4
    } commit_src_e;

    typedef struct packed {
        logic [UUID_BITS-1:0]      uuid;
        logic [NW_BITS-1:0]        wid;
        logic [NUM_THREADS-1:0]    tmask;
        logic [31:0]               PC;
        logic [NUM_THREADS*32-1:0] data;
        logic [NR_BITS-1:0]        rd;
        logic                      eop;
    } commit_pkt_t;

    typedef struct packed {
        logic        valid;
        commit_pkt_t pkt;
    } wb_pkt_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// One-hot round-robin arbiter. The pointer holds the last granted index; the search
// starts one past it, so after reset (pointer = last index) source 0 has top priority.
module vx_rr_arbiter #(
    parameter int NUM_REQS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req,
    input  logic                enable,
    output logic [NUM_REQS-1:0] grant,
    output logic                grant_valid
);
    localparam int PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQS - 1);

    logic [PTR_W-1:0] r_last;
    logic [PTR_W-1:0] w_next;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant   = '0;
        w_next  = r_last;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            w_idx = (w_idx == LAST_IDX) ? '0 : w_idx + PTR_W'(1);
            if (enable && !w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                w_next       = w_idx;
            end
        end
    end

    assign grant_valid = w_found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= LAST_IDX;
        end else if (w_found) begin
            r_last <= w_next;
        end
    end

endmodule

// File: rtl/vx_commit_writeback.sv
// Commit stage: arbitrates register-writing commits onto one registered writeback port,
// retires non-writing commits at once and counts instret. Optional stall counter: VX_COMMIT_PERF_EN.
module vx_commit_writeback
    import vx_commit_pkg::*;
#(
    parameter int NUM_SRCS = int'(SRC_GPU) + 1,
    parameter int CNT_W    = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_SRCS-1:0]                commit_valid,
    input  logic [NUM_SRCS*UUID_BITS-1:0]      commit_uuid,
    input  logic [NUM_SRCS*NW_BITS-1:0]        commit_wid,
    input  logic [NUM_SRCS*NUM_THREADS-1:0]    commit_tmask,
    input  logic [NUM_SRCS*32-1:0]             commit_PC,
    input  logic [NUM_SRCS*NUM_THREADS*32-1:0] commit_data,
    input  logic [NUM_SRCS*NR_BITS-1:0]        commit_rd,
    input  logic [NUM_SRCS-1:0]                commit_wb,
    input  logic [NUM_SRCS-1:0]                commit_eop,
    output logic [NUM_SRCS-1:0]                commit_ready,
    output logic                               wb_valid,
    output logic [UUID_BITS-1:0]               wb_uuid,
    output logic [NW_BITS-1:0]                 wb_wid,
    output logic [NUM_THREADS-1:0]             wb_tmask,
    output logic [31:0]                        wb_PC,
    output logic [NUM_THREADS*32-1:0]          wb_data,
    output logic [NR_BITS-1:0]                 wb_rd,
    output logic                               wb_eop,
    output logic [CNT_W-1:0]                   instret,
    output logic [PERF_CTR_W-1:0]              perf_wb_stalls
);
    localparam int DW = NUM_THREADS * 32;

    logic [NUM_SRCS-1:0] w_req;
    logic [NUM_SRCS-1:0] w_grant;
    logic                w_grant_valid;
    logic [NUM_SRCS-1:0] w_fire;
    logic [NUM_SRCS-1:0] w_retire;
    logic [CNT_W-1:0]    w_ret_cnt;
    commit_pkt_t         w_sel;
    wb_pkt_t             r_wb;
    logic [CNT_W-1:0]    r_instret;

    assign w_req = commit_valid & commit_wb;

    // The regfile never stalls, so the arbiter is always enabled.
    vx_rr_arbiter #(
        .NUM_REQS (NUM_SRCS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (w_req),
        .enable      (1'b1),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign commit_ready = ~commit_wb | w_grant;
    assign w_fire       = commit_valid & commit_ready;
    assign w_retire     = w_fire & commit_eop;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (w_grant[i]) begin
                w_sel.uuid  = commit_uuid[i*UUID_BITS +: UUID_BITS];
                w_sel.wid   = commit_wid[i*NW_BITS +: NW_BITS];
                w_sel.tmask = commit_tmask[i*NUM_THREADS +: NUM_THREADS];
                w_sel.PC    = commit_PC[i*32 +: 32];
                w_sel.data  = commit_data[i*DW +: DW];
                w_sel.rd    = commit_rd[i*NR_BITS +: NR_BITS];
                w_sel.eop   = commit_eop[i];
            end
        end
    end

    always_comb begin
        w_ret_cnt = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            w_ret_cnt = w_ret_cnt + CNT_W'(w_retire[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb      <= '0;
            r_instret <= '0;
        end else begin
            r_wb.valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_wb.pkt <= w_sel;
            end
            r_instret <= r_instret + w_ret_cnt;
        end
    end

    assign wb_valid = r_wb.valid;
    assign wb_uuid  = r_wb.pkt.uuid;
    assign wb_wid   = r_wb.pkt.wid;
    assign wb_tmask = r_wb.pkt.tmask;
    assign wb_PC    = r_wb.pkt.PC;
    assign wb_data  = r_wb.pkt.data;
    assign wb_rd    = r_wb.pkt.rd;
    assign wb_eop   = r_wb.pkt.eop;
    assign instret  = r_instret;

`ifdef VX_COMMIT_PERF_EN
    logic [PERF_CTR_W-1:0] r_stalls;
    logic                  w_multi;

    // More than one bit set in req means someone lost arbitration this cycle.
    assign w_multi = |(w_req & (w_req - NUM_SRCS'(1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stalls <= '0;
        end else if (w_multi && (r_stalls != '1)) begin
            r_stalls <= r_stalls + PERF_CTR_W'(1);
        end
    end

    assign perf_wb_stalls = r_stalls;
`else
    assign perf_wb_stalls = '0;
`endif

endmodule

// File: tb/tb_vx_commit_writeback.sv
// Directed self-checking bench for vx_commit_writeback: round-robin order, ready,
// retire counting, payload hold, instret wrap, mid-stream reset and the stall counter.
module tb_vx_commit_writeback;
    import vx_commit_pkg::*;

    localparam int NS = 5;
    localparam int DW = NUM_THREADS * 32;
`ifdef VX_COMMIT_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic                            clk;
    logic                            reset;
    logic [NS-1:0]                   commit_valid;
    logic [NS*UUID_BITS-1:0]         commit_uuid;
    logic [NS*NW_BITS-1:0]           commit_wid;
    logic [NS*NUM_THREADS-1:0]       commit_tmask;
    logic [NS*32-1:0]                commit_PC;
    logic [NS*DW-1:0]                commit_data;
    logic [NS*NR_BITS-1:0]           commit_rd;
    logic [NS-1:0]                   commit_wb;
    logic [NS-1:0]                   commit_eop;
    logic [NS-1:0]                   commit_ready;
    logic                            wb_valid;
    logic [UUID_BITS-1:0]            wb_uuid;
    logic [NW_BITS-1:0]              wb_wid;
    logic [NUM_THREADS-1:0]          wb_tmask;
    logic [31:0]                     wb_PC;
    logic [DW-1:0]                   wb_data;
    logic [NR_BITS-1:0]              wb_rd;
    logic                            wb_eop;
    logic [63:0]                     instret;
    logic [PERF_CTR_W-1:0]           perf_wb_stalls;

    int n_checks = 0;
    int n_errors = 0;

    vx_commit_writeback #(.NUM_SRCS(NS), .CNT_W(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .commit_valid   (commit_valid),
        .commit_uuid    (commit_uuid),
        .commit_wid     (commit_wid),
        .commit_tmask   (commit_tmask),
        .commit_PC      (commit_PC),
        .commit_data    (commit_data),
        .commit_rd      (commit_rd),
        .commit_wb      (commit_wb),
        .commit_eop     (commit_eop),
        .commit_ready   (commit_ready),
        .wb_valid       (wb_valid),
        .wb_uuid        (wb_uuid),
        .wb_wid         (wb_wid),
        .wb_tmask       (wb_tmask),
        .wb_PC          (wb_PC),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_eop         (wb_eop),
        .instret        (instret),
        .perf_wb_stalls (perf_wb_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] data_of(input logic [7:0] tag);
        logic [DW-1:0] d;
        for (int j = 0; j < NUM_THREADS; j++) begin
            d[j*32 +: 32] = {16'hDA7A, tag, 8'(j)};
        end
        return d;
    endfunction

    task automatic set_src(input int i, input logic v, input logic w, input logic e,
                           input logic [7:0] tag);
        commit_valid[i] = v;
        commit_wb[i]    = w;
        commit_eop[i]   = e;
        commit_uuid[i*UUID_BITS +: UUID_BITS]      = UUID_BITS'(tag);
        commit_wid[i*NW_BITS +: NW_BITS]           = tag[NW_BITS-1:0];
        commit_tmask[i*NUM_THREADS +: NUM_THREADS] = tag[NUM_THREADS-1:0];
        commit_PC[i*32 +: 32]                      = {22'h200000, tag, 2'b00};
        commit_data[i*DW +: DW]                    = data_of(tag);
        commit_rd[i*NR_BITS +: NR_BITS]            = tag[NR_BITS-1:0];
    endtask

    task automatic all_idle();
        for (int i = 0; i < NS; i++) set_src(i, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, 1'b1, 1'b1, 8'(8'h10 + i));

        // reset held with every source requesting
        tick();
        tick();
        chk("rst_wb_valid", 128'(wb_valid), 128'd0);
        chk("rst_instret",  128'(instret),  128'd0);
        chk("rst_perf",     128'(perf_wb_stalls), 128'd0);
        chk("rst_uuid",     128'(wb_uuid),  128'd0);
        chk("rst_ready",    128'(commit_ready), 128'h01);

        // all five requesting for ten cycles: grants rotate 0..4
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_ready", 128'(commit_ready), 128'(5'b00001 << (k % 5)));
            tick();
            chk("rr_wb_valid", 128'(wb_valid), 128'd1);
            chk("rr_uuid",     128'(wb_uuid),  128'(8'h10 + (k % 5)));
            chk("rr_data",     128'(wb_data),  128'(data_of(8'(8'h10 + (k % 5)))));
            chk("rr_instret",  128'(instret),  128'(k + 1));
        end
        chk("rr_perf", 128'(perf_wb_stalls), PERF_ON ? 128'd10 : 128'd0);

        // mixed: 1 and 3 retire without writing, 2 writes
        set_src(0, 1'b0, 1'b1, 1'b1, 8'h00);
        set_src(1, 1'b1, 1'b0, 1'b1, 8'h21);
        set_src(2, 1'b1, 1'b1, 1'b1, 8'h22);
        set_src(3, 1'b1, 1'b0, 1'b1, 8'h23);
        set_src(4, 1'b0, 1'b1, 1'b1, 8'h00);
        #1;
        chk("mix_ready", 128'(commit_ready), 128'h0E);
        tick();
        chk("mix_wb_valid", 128'(wb_valid), 128'd1);
        chk("mix_uuid",     128'(wb_uuid),  128'h22);
        chk("mix_data",     128'(wb_data),  128'(data_of(8'h22)));
        chk("mix_pc",       128'(wb_PC),    128'h8000_0088);
        chk("mix_rd",       128'(wb_rd),    128'h02);
        chk("mix_instret",  128'(instret),  128'd13);

        // idle: valid drops, payload holds
        all_idle();
        tick();
        chk("idle_wb_valid", 128'(wb_valid), 128'd0);
        chk("idle_uuid_hold", 128'(wb_uuid), 128'h22);
        chk("idle_instret",  128'(instret),  128'd13);

        // source 4: two non-final packets then the final one
        for (int p = 0; p < 3; p++) begin
            set_src(4, 1'b1, 1'b1, (p == 2), 8'(8'h40 + p));
            #1;
            chk("pkt_ready", 128'(commit_ready), 128'h1F);
            tick();
            chk("pkt_wb_valid", 128'(wb_valid), 128'd1);
            chk("pkt_uuid",     128'(wb_uuid),  128'(8'h40 + p));
            chk("pkt_eop",      128'(wb_eop),   128'((p == 2) ? 1 : 0));
            chk("pkt_instret",  128'(instret),  (p == 2) ? 128'd14 : 128'd13);
        end

        // instret wrap from 2^64-2 with three retires in one cycle
        all_idle();
        tick();
        chk("wrap_pre_wb_valid", 128'(wb_valid), 128'd0);
        dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
        set_src(0, 1'b1, 1'b0, 1'b1, 8'h01);
        set_src(1, 1'b1, 1'b0, 1'b1, 8'h02);
        set_src(2, 1'b1, 1'b0, 1'b1, 8'h03);
        #1;
        chk("wrap_ready", 128'(commit_ready), 128'h1F);
        tick();
        chk("wrap_instret",  128'(instret),  128'd1);
        chk("wrap_wb_valid", 128'(wb_valid), 128'd0);

        // reset while a writeback is in flight
        all_idle();
        set_src(2, 1'b1, 1'b1, 1'b1, 8'h55);
        tick();
        chk("inflight_wb_valid", 128'(wb_valid), 128'd1);
        chk("inflight_uuid",     128'(wb_uuid),  128'h55);
        reset = 1'b0;
        #1;
        chk("midrst_wb_valid", 128'(wb_valid), 128'd0);
        chk("midrst_uuid",     128'(wb_uuid),  128'd0);
        chk("midrst_instret",  128'(instret),  128'd0);
        chk("midrst_perf",     128'(perf_wb_stalls), 128'd0);
        all_idle();
        tick();
        reset = 1'b1;

        // four contended cycles, then three single-requester cycles
        set_src(0, 1'b1, 1'b1, 1'b1, 8'h60);
        set_src(1, 1'b1, 1'b1, 1'b1, 8'h61);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("perf2_uuid",    128'(wb_uuid), 128'(8'h60 + (c % 2)));
            chk("perf2_instret", 128'(instret), 128'(c + 1));
        end
        set_src(0, 1'b0, 1'b0, 1'b0, 8'h00);
        set_src(1, 1'b0, 1'b0, 1'b0, 8'h00);
        set_src(3, 1'b1, 1'b1, 1'b1, 8'h63);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("perf1_uuid",    128'(wb_uuid), 128'h63);
            chk("perf1_instret", 128'(instret), 128'(c + 5));
        end
        chk("perf_final", 128'(perf_wb_stalls), PERF_ON ? 128'd4 : 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
